gfsk_vco: RTL and testbench

- Downstream neighbour of gauss_filter in the BTLE TX chain.
- Integrates the Gaussian-filtered frequency samples into a wrapping phase accumulator and maps phase to I/Q through runtime-loadable cos/sin tables.
- Output feeds the DAC/IQ interface at the same 8M sample rate as the filter output.

---
 rtl/gfsk_vco_pkg.sv | 15 +
 rtl/gfsk_vco_if.sv | 40 ++++
 rtl/gfsk_vco_table.sv | 45 ++++
 rtl/gfsk_vco.sv | 92 +++++++++
 tb/tb_gfsk_vco.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/gfsk_vco_pkg.sv
// Shared definitions for the GFSK VCO stage of the BTLE TX chain.
// Holds the default datapath widths and the packet state encoding.
package gfsk_vco_pkg;

  localparam int unsigned GAUSS_FILTER_BIT_WIDTH = 16;
  localparam int unsigned VCO_BIT_WIDTH          = 16;
  localparam int unsigned SIN_COS_ADDR_BIT_WIDTH = 11;
  localparam int unsigned IQ_BIT_WIDTH           = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } vco_state_e;

endpackage

// File: rtl/gfsk_vco_if.sv
// Bundle of the gfsk_vco stream and table-load signals.
//   table write : cos_table_write_address, cos/sin_table_write_data, table_write_en
//   input stream: bit_upsample_gauss_filter(+_valid, +_valid_last)
//   output I/Q  : cos_out, sin_out, cos_sin_out_valid, cos_sin_out_valid_last
// master drives the table/input side and observes I/Q; slave is the VCO.
interface gfsk_vco_if
  import gfsk_vco_pkg::*;
#(
  parameter int unsigned GaussWidth = GAUSS_FILTER_BIT_WIDTH,
  parameter int unsigned AddrWidth  = SIN_COS_ADDR_BIT_WIDTH,
  parameter int unsigned IqWidth    = IQ_BIT_WIDTH
) ();

  logic [AddrWidth-1:0]  cos_table_write_address;
  logic [IqWidth-1:0]    cos_table_write_data;
  logic [IqWidth-1:0]    sin_table_write_data;
  logic                  table_write_en;
  logic [GaussWidth-1:0] bit_upsample_gauss_filter;
  logic                  bit_upsample_gauss_filter_valid;
  logic                  bit_upsample_gauss_filter_valid_last;
  logic [IqWidth-1:0]    cos_out;
  logic [IqWidth-1:0]    sin_out;
  logic                  cos_sin_out_valid;
  logic                  cos_sin_out_valid_last;

  modport master (
    output cos_table_write_address, cos_table_write_data, sin_table_write_data, table_write_en,
    output bit_upsample_gauss_filter, bit_upsample_gauss_filter_valid,
    output bit_upsample_gauss_filter_valid_last,
    input  cos_out, sin_out, cos_sin_out_valid, cos_sin_out_valid_last
  );

  modport slave (
    input  cos_table_write_address, cos_table_write_data, sin_table_write_data, table_write_en,
    input  bit_upsample_gauss_filter, bit_upsample_gauss_filter_valid,
    input  bit_upsample_gauss_filter_valid_last,
    output cos_out, sin_out, cos_sin_out_valid, cos_sin_out_valid_last
  );

endinterface

// File: rtl/gfsk_vco_table.sv
// Cos/sin lookup RAM: one write port loading both tables at the same address,
// one synchronous read port with a resettable, enable-gated output register.
//   clk, rst           : clock, synchronous active-high reset (output register only)
//   wr_en/wr_addr      : write strobe and address
//   wr_cos/wr_sin      : entries written side by side
//   rd_en/rd_addr      : read strobe and address
//   rd_cos/rd_sin      : registered read data, held while rd_en is low
module gfsk_vco_table #(
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned IqWidth   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [IqWidth-1:0]   wr_cos,
  input  logic [IqWidth-1:0]   wr_sin,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [IqWidth-1:0]   rd_cos,
  output logic [IqWidth-1:0]   rd_sin
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [2*IqWidth-1:0] mem [Depth];

  // Contents survive reset; they are loaded by software.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_cos, wr_sin};
    end
  end

  // Same-address read during a write sees the old entry (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cos <= '0;
      rd_sin <= '0;
    end else if (rd_en) begin
      {rd_cos, rd_sin} <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/gfsk_vco.sv
// GFSK VCO: integrates Gaussian-filtered frequency samples into a wrapping phase
// accumulator and maps phase to I/Q through loadable cos/sin tables.
// Two-stage pipeline (phase/address, then table read); 2 clk input-to-output.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : gfsk_vco_if slave (table load, input stream, I/Q output)
module gfsk_vco
  import gfsk_vco_pkg::*;
#(
  parameter int unsigned GaussWidth = GAUSS_FILTER_BIT_WIDTH,
  parameter int unsigned VcoWidth   = VCO_BIT_WIDTH,
  parameter int unsigned AddrWidth  = SIN_COS_ADDR_BIT_WIDTH,
  parameter int unsigned IqWidth    = IQ_BIT_WIDTH
) (
  input logic        clk,
  input logic        rst,
  gfsk_vco_if.slave  bus
);

  vco_state_e            state_q, state_d;
  logic [VcoWidth-1:0]   phase_q;
  logic [VcoWidth-1:0]   phase_next;
  logic [VcoWidth-1:0]   sample_ext;
  logic [AddrWidth-1:0]  addr_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  in_valid;
  logic                  in_last;

  assign in_valid   = bus.bit_upsample_gauss_filter_valid;
  assign in_last    = bus.bit_upsample_gauss_filter_valid & bus.bit_upsample_gauss_filter_valid_last;
  assign sample_ext = VcoWidth'($signed(bus.bit_upsample_gauss_filter));
  assign phase_next = phase_q + sample_ext;

  // A last sample always lands in IDLE, even when the packet is one sample long.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = in_last ? StIdle : StRun;
      StRun:  if (in_last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: accumulate phase and register the truncated table address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= in_valid;
      last_q  <= in_last;
      if (in_valid) begin
        addr_q  <= phase_next[VcoWidth-1 -: AddrWidth];
        // The sample that ends a packet is used, then phase restarts from 0.
        phase_q <= (state_d == StIdle) ? '0 : phase_next;
      end
    end
  end

  // Stage 2: table lookup; the output register holds while no valid is piped.
  gfsk_vco_table #(
    .AddrWidth (AddrWidth),
    .IqWidth   (IqWidth)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.table_write_en),
    .wr_addr (bus.cos_table_write_address),
    .wr_cos  (bus.cos_table_write_data),
    .wr_sin  (bus.sin_table_write_data),
    .rd_en   (valid_q),
    .rd_addr (addr_q),
    .rd_cos  (bus.cos_out),
    .rd_sin  (bus.sin_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cos_sin_out_valid      <= 1'b0;
      bus.cos_sin_out_valid_last <= 1'b0;
    end else begin
      bus.cos_sin_out_valid      <= valid_q;
      bus.cos_sin_out_valid_last <= last_q;
    end
  end

endmodule

// File: tb/tb_gfsk_vco.sv
// Directed bench for gfsk_vco. Tables are loaded with cos[a]=a[7:0], sin[a]=~a[7:0].
// Each vector row is driven for one clk; its expected fields are the outputs seen
// just after that clk edge, i.e. the result of the row two cycles back in time.
module tb_gfsk_vco;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #31 clk = ~clk;

  gfsk_vco_if vif ();

  gfsk_vco u_dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  typedef struct {
    logic signed [15:0] sample;
    logic               v;
    logic               l;
    logic               ev;
    logic               el;
    logic [7:0]         ec;
    logic [7:0]         es;
  } vec_t;

  vec_t vecs [20];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic ev, input logic el,
                       input logic [7:0] ec, input logic [7:0] es);
    checks++;
    if (vif.cos_sin_out_valid !== ev || vif.cos_sin_out_valid_last !== el ||
        vif.cos_out !== ec || vif.sin_out !== es) begin
      errors++;
      $display("FAIL %s: got valid=%b last=%b cos=%h sin=%h, want valid=%b last=%b cos=%h sin=%h",
               name, vif.cos_sin_out_valid, vif.cos_sin_out_valid_last, vif.cos_out,
               vif.sin_out, ev, el, ec, es);
    end
  endtask

  task automatic drive(input logic signed [15:0] s, input logic v, input logic l);
    vif.bit_upsample_gauss_filter            = s;
    vif.bit_upsample_gauss_filter_valid      = v;
    vif.bit_upsample_gauss_filter_valid_last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vif.table_write_en          = 1'b0;
    vif.cos_table_write_address = '0;
    vif.cos_table_write_data    = '0;
    vif.sin_table_write_data    = '0;
    drive(16'sd0, 1'b0, 1'b0);

    //        sample         v  l   ev el  cos    sin
    vecs[0]  = '{16'sd2048,  1, 0,  0, 0, 8'h00, 8'h00};
    vecs[1]  = '{16'sd0,     0, 0,  1, 0, 8'h40, 8'hBF};
    vecs[2]  = '{16'sd2048,  1, 0,  0, 0, 8'h40, 8'hBF};
    vecs[3]  = '{16'sd0,     0, 0,  1, 0, 8'h80, 8'h7F};
    vecs[4]  = '{16'sd2048,  1, 0,  0, 0, 8'h80, 8'h7F};
    vecs[5]  = '{16'sd0,     0, 0,  1, 0, 8'hC0, 8'h3F};
    vecs[6]  = '{16'sd2048,  1, 1,  0, 0, 8'hC0, 8'h3F};
    vecs[7]  = '{16'sd0,     0, 0,  1, 1, 8'h00, 8'hFF};
    vecs[8]  = '{-16'sd4096, 1, 0,  0, 0, 8'h00, 8'hFF};  // phase 0xF000
    vecs[9]  = '{16'sh2000,  1, 1,  1, 0, 8'h80, 8'h7F};  // wraps to 0x1000
    vecs[10] = '{-16'sd1024, 1, 1,  1, 1, 8'h80, 8'h7F};  // fresh phase -> 0xFC00
    vecs[11] = '{16'sd0,     0, 0,  1, 1, 8'hE0, 8'h1F};
    vecs[12] = '{16'sd512,   1, 0,  0, 0, 8'hE0, 8'h1F};
    vecs[13] = '{16'sd512,   1, 0,  1, 0, 8'h10, 8'hEF};
    vecs[14] = '{16'sd512,   1, 1,  1, 0, 8'h20, 8'hDF};
    vecs[15] = '{16'sd512,   1, 0,  1, 1, 8'h30, 8'hCF};
    vecs[16] = '{16'sd0,     0, 1,  1, 0, 8'h10, 8'hEF};  // stray last without valid
    vecs[17] = '{16'sd512,   1, 1,  0, 0, 8'h10, 8'hEF};
    vecs[18] = '{16'sd0,     0, 0,  1, 1, 8'h20, 8'hDF};
    vecs[19] = '{16'sd0,     0, 0,  0, 0, 8'h20, 8'hDF};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 8'h00, 8'h00);

    // Table load while still in reset: contents are independent of reset.
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] addr;
      addr = 11'(a);
      vif.table_write_en          = 1'b1;
      vif.cos_table_write_address = addr;
      vif.cos_table_write_data    = addr[7:0];
      vif.sin_table_write_data    = ~addr[7:0];
      tick();
    end
    vif.table_write_en = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].sample, vecs[i].v, vecs[i].l);
      tick();
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].el, vecs[i].ec, vecs[i].es);
    end
    drive(16'sd0, 1'b0, 1'b0);

    // Write to address 64 concurrent with its table read: old entry first, new one next.
    drive(16'sd2048, 1'b1, 1'b1);
    tick();
    vif.table_write_en          = 1'b1;
    vif.cos_table_write_address = 11'd64;
    vif.cos_table_write_data    = 8'h11;
    vif.sin_table_write_data    = 8'h22;
    tick();
    vif.table_write_en = 1'b0;
    drive(16'sd0, 1'b0, 1'b0);
    check("rw_old_data", 1'b1, 1'b1, 8'h40, 8'hBF);
    // Restore entry 64 while the repeat sample's read is already past.
    tick();
    check("rw_new_data", 1'b1, 1'b1, 8'h11, 8'h22);
    vif.table_write_en          = 1'b1;
    vif.cos_table_write_data    = 8'h40;
    vif.sin_table_write_data    = 8'hBF;
    tick();
    vif.table_write_en = 1'b0;

    // Reset with two samples in flight: pipeline flushed, phase back to 0.
    drive(16'sd2048, 1'b1, 1'b0);
    tick();
    drive(16'sd2048, 1'b1, 1'b0);
    tick();
    drive(16'sd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_reset_outputs", 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    check("post_reset_flush0", 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("post_reset_flush1", 1'b0, 1'b0, 8'h00, 8'h00);
    drive(16'sd2048, 1'b1, 1'b1);
    tick();
    drive(16'sd0, 1'b0, 1'b0);
    tick();
    check("post_reset_first", 1'b1, 1'b1, 8'h40, 8'hBF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
